rv32_fetch_unit: RTL and testbench

- Instruction-fetch front end of the thoth-rv32 core, instantiated inside top and feeding the decode stage.
- Holds the PC and issues word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing buffered and in-flight fetches.

---
 rtl/rv32_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_rv32_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch_unit.sv
// Instruction-fetch front end: PC generation, imem request/response tracking,
// instruction buffer toward decode, and redirect flush of buffered/in-flight fetches.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [31:0]   RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        ST_BOOT,
        ST_FETCH
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_pq_rd;
    logic [AW-1:0] r_pq_wr;
    logic [31:0]   r_fifo_pc  [FIFO_DEPTH];
    logic [31:0]   r_fifo_ins [FIFO_DEPTH];
    logic [31:0]   r_pcq      [FIFO_DEPTH];

    logic [CW:0]   w_inflight;
    logic          w_req;
    logic          w_grant;
    logic          w_rsp;
    logic          w_drop;
    logic          w_accept;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;
    logic          w_unused;

    // Buffered plus in-flight (including to-be-discarded) never exceeds the buffer size,
    // so an accepted response always finds a free slot.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
    assign w_req      = (r_state == ST_FETCH) && (w_inflight < DEPTH_W) && !redirect_i;
    assign w_grant    = w_req && imem_gnt_i;
    assign w_rsp      = imem_rvalid_i && (r_outst != '0);
    assign w_drop     = w_rsp && (r_discard != '0);
    assign w_accept   = w_rsp && (r_discard == '0);
    assign w_push     = w_accept && !redirect_i;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && if_ready_i;
    assign w_unused   = ^redirect_pc_i[1:0];

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign if_valid_o  = w_valid;
    assign if_pc_o     = r_fifo_pc[r_rd_ptr];
    assign if_instr_o  = r_fifo_ins[r_rd_ptr];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC_ALIGNED;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            if (r_state == ST_BOOT) begin
                r_state <= ST_FETCH;
            end

            if (redirect_i) begin
                r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            case ({w_grant, w_rsp})
                2'b10:   r_outst <= r_outst + CNT_ONE;
                2'b01:   r_outst <= r_outst - CNT_ONE;
                default: r_outst <= r_outst;
            endcase

            // No grant can coincide with a redirect, so everything left in flight is stale.
            if (redirect_i) begin
                r_discard <= r_outst - (w_rsp ? CNT_ONE : '0);
            end else if (w_drop) begin
                r_discard <= r_discard - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pq_rd <= '0;
            r_pq_wr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_pcq[i] <= '0;
            end
        end else if (redirect_i) begin
            r_pq_rd <= '0;
            r_pq_wr <= '0;
        end else begin
            if (w_grant) begin
                r_pcq[r_pq_wr] <= r_fetch_pc;
                r_pq_wr        <= r_pq_wr + PTR_ONE;
            end
            if (w_accept) begin
                r_pq_rd <= r_pq_rd + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]  <= '0;
                r_fifo_ins[i] <= '0;
            end
        end else if (redirect_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]  <= r_pcq[r_pq_rd];
                r_fifo_ins[r_wr_ptr] <= imem_rdata_i;
                r_wr_ptr             <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit: startup vector table, directed corner
// sequences, and a randomized run against an in-order memory and PC-stream reference.
module tb_rv32_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        reset_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    rv32_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [8];

    int n_pass  = 0;
    int n_total = 0;
    int cyc;
    int g_gnt_pct, g_rdy_pct, g_rsp_pct, g_lat_max, g_redir_pct;
    bit mem_hold;
    logic [31:0] mq_addr [$];
    int          mq_rdy  [$];
    logic [31:0] exp_pc, exp_issue;
    int n_pops, n_grants;
    logic [31:0] last_pop_pc, last_grant_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic bit coin(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic set_mode(input int gnt, input int rdy, input int rsp, input int lat, input int redir);
        g_gnt_pct   = gnt;
        g_rdy_pct   = rdy;
        g_rsp_pct   = rsp;
        g_lat_max   = lat;
        g_redir_pct = redir;
    endtask

    task automatic drive_inputs();
        imem_gnt_i    = coin(g_gnt_pct);
        if_ready_i    = coin(g_rdy_pct);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (!mem_hold && mq_addr.size() != 0 && mq_rdy[0] <= cyc && coin(g_rsp_pct)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq_addr[0]);
        end
        redirect_i    = coin(g_redir_pct);
        redirect_pc_i = $urandom;
    endtask

    // One clock: sample at negedge, update memory/reference after the posedge, drive next inputs.
    task automatic step(input int row = -1);
        logic        s_pop, s_gnt, s_rsp, s_redir;
        logic [31:0] s_pc, s_ins, s_addr, s_rpc;
        @(negedge clk);
        s_pop   = if_valid_o && if_ready_i;
        s_pc    = if_pc_o;
        s_ins   = if_instr_o;
        s_gnt   = imem_req_o && imem_gnt_i;
        s_addr  = imem_addr_o;
        s_rsp   = imem_rvalid_i;
        s_redir = redirect_i;
        s_rpc   = redirect_pc_i;
        if (s_redir) check("req_low_in_redirect", {31'b0, imem_req_o}, 32'd0);
        if (imem_req_o) check("addr_aligned", {30'b0, imem_addr_o[1:0]}, 32'd0);
        if (row >= 0) begin
            check("tbl_req", {31'b0, imem_req_o}, {31'b0, tbl[row].req});
            check("tbl_addr", imem_addr_o, tbl[row].addr);
            check("tbl_valid", {31'b0, if_valid_o}, {31'b0, tbl[row].vld});
            if (tbl[row].vld) begin
                check("tbl_pc", if_pc_o, tbl[row].pc);
                check("tbl_instr", if_instr_o, mem_word(tbl[row].pc));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_rsp && mq_addr.size() != 0) begin
            void'(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
        end
        if (s_pop) begin
            check("pop_pc", s_pc, exp_pc);
            check("pop_instr", s_ins, mem_word(exp_pc));
            exp_pc      = exp_pc + 32'd4;
            last_pop_pc = s_pc;
            n_pops++;
        end
        if (s_gnt) begin
            check("grant_addr", s_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
            mq_addr.push_back(s_addr);
            mq_rdy.push_back(cyc + $urandom_range(g_lat_max, 0));
            last_grant_addr = s_addr;
            n_grants++;
        end
        if (s_redir) begin
            exp_pc    = {s_rpc[31:2], 2'b00};
            exp_issue = {s_rpc[31:2], 2'b00};
            check("valid_after_redirect", {31'b0, if_valid_o}, 32'd0);
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_ni      = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        if_ready_i    = 1'b0;
        mem_hold      = 1'b0;
        mq_addr.delete();
        mq_rdy.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_valid", {31'b0, if_valid_o}, 32'd0);
        check("rst_pc", if_pc_o, 32'd0);
        check("rst_instr", if_instr_o, 32'd0);
        reset_ni  = 1'b1;
        cyc       = 0;
        exp_pc    = RST_PC;
        exp_issue = RST_PC;
        drive_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g0, p0;
        bit  found;
        reset_ni = 1'b0;
        cyc = 0; n_pops = 0; n_grants = 0;
        last_pop_pc = '0; last_grant_addr = '0;

        // Startup with always-grant, zero-wait memory, decode always ready.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        set_mode(100, 100, 100, 0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            imem_gnt_i = tbl[i].gnt;
            if_ready_i = tbl[i].rdy;
            step(i);
        end

        // Backpressure fills the buffer, then drains exactly two in order.
        set_mode(100, 0, 100, 0, 0);
        do_reset();
        repeat (7) step();
        check("bp_req_low", {31'b0, imem_req_o}, 32'd0);
        check("bp_valid", {31'b0, if_valid_o}, 32'd1);
        check("bp_head_pc", if_pc_o, RST_PC);
        p0 = n_pops;
        set_mode(0, 100, 100, 0, 0);
        imem_gnt_i = 1'b0;
        if_ready_i = 1'b1;
        repeat (5) step();
        check("bp_drain_count", n_pops - p0, 32'd2);
        check("bp_empty", {31'b0, if_valid_o}, 32'd0);

        // Grant withheld: address and PC hold, nothing new delivered.
        check("stall_addr_init", imem_addr_o, RST_PC + 32'd8);
        repeat (4) begin
            step();
            check("stall_addr_stable", imem_addr_o, RST_PC + 32'd8);
            check("stall_req_held", {31'b0, imem_req_o}, 32'd1);
            check("stall_no_valid", {31'b0, if_valid_o}, 32'd0);
        end

        // Redirect with two responses in flight.
        set_mode(100, 100, 100, 0, 0);
        do_reset();
        mem_hold = 1'b1;
        repeat (3) step();
        check("rd_req_blocked", {31'b0, imem_req_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        g0 = n_grants;
        p0 = n_pops;
        step();
        mem_hold = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (n_grants > g0) found = 1'b1;
        end
        check("rd_grant_seen", {31'b0, found}, 32'd1);
        check("rd_first_addr", last_grant_addr, 32'h0000_0100);
        found = (n_pops > p0);
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (n_pops > p0) found = 1'b1;
        end
        check("rd_pop_seen", {31'b0, found}, 32'd1);
        check("rd_first_pc", last_pop_pc, 32'h0000_0100);

        // Fetch address wraps at the top of the address space.
        set_mode(100, 100, 100, 0, 0);
        do_reset();
        repeat (3) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        g0 = n_grants;
        p0 = n_pops;
        step();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (n_grants > g0) found = 1'b1;
        end
        check("wrap_grant_seen", {31'b0, found}, 32'd1);
        check("wrap_top_addr", last_grant_addr, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr_o, 32'h0000_0000);
        repeat (8) step();
        check("wrap_progress", {31'b0, (n_pops - p0 >= 2)}, 32'd1);

        // Asynchronous reset while the buffer is full.
        set_mode(100, 0, 100, 0, 0);
        do_reset();
        repeat (6) step();
        check("full_valid", {31'b0, if_valid_o}, 32'd1);
        check("full_req", {31'b0, imem_req_o}, 32'd0);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_valid", {31'b0, if_valid_o}, 32'd0);
        check("async_req", {31'b0, imem_req_o}, 32'd0);
        check("async_addr", imem_addr_o, RST_PC);
        check("async_pc", if_pc_o, 32'd0);
        check("async_instr", if_instr_o, 32'd0);
        set_mode(100, 100, 100, 0, 0);
        do_reset();
        p0 = n_pops;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (n_pops > p0) found = 1'b1;
        end
        check("restart_pop_seen", {31'b0, found}, 32'd1);
        check("restart_pc", last_pop_pc, RST_PC);

        // Randomized traffic, latency, backpressure and redirects.
        set_mode(70, 60, 70, 3, 3);
        do_reset();
        p0 = n_pops;
        repeat (3000) step();
        check("rand_progress", {31'b0, (n_pops - p0 > 100)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
